// File: rtl/sr_fifo_pkg.sv
// Shared types and helpers for the shift-register FIFO controller.
// Holds the per-cycle operation decode and the occupancy width function.
package sr_fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b10,
        OP_POP  = 2'b01,
        OP_BOTH = 2'b11
    } fifo_op_t;

    function automatic int pcw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sr_occ_cnt.sv
// Occupancy counter for the shift-register FIFO.
// Tracks pc from accepted push/pop and derives the level flags.
module sr_occ_cnt
    import sr_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PCW   = pcw(DEPTH)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_push_ok,
    input  logic           i_pop_ok,
    output logic [PCW-1:0] o_pc,
    output logic           o_full,
    output logic           o_empty,
    output logic           o_almost_full
);

    localparam logic [PCW-1:0] LP_FULL = PCW'(DEPTH);
    localparam logic [PCW-1:0] LP_AF   = PCW'(DEPTH - 1);

    logic [PCW-1:0] r_pc;
    logic [PCW-1:0] w_pc_nxt;
    fifo_op_t       w_op;

    assign w_op = fifo_op_t'({i_push_ok, i_pop_ok});

    // Saturating guards keep pc inside 0..DEPTH even if acceptance misbehaves.
    always_comb begin
        w_pc_nxt = r_pc;
        unique case (w_op)
            OP_PUSH: begin
                if (r_pc != LP_FULL)
                    w_pc_nxt = r_pc + PCW'(1);
            end
            OP_POP: begin
                if (r_pc != '0)
                    w_pc_nxt = r_pc - PCW'(1);
            end
            OP_IDLE: w_pc_nxt = r_pc;
            OP_BOTH: w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_pc <= '0;
        else
            r_pc <= w_pc_nxt;
    end

    assign o_pc          = r_pc;
    assign o_full        = (r_pc == LP_FULL);
    assign o_empty       = (r_pc == '0);
    assign o_almost_full = (r_pc >= LP_AF);

endmodule

// File: rtl/sr_fifo_ctrl.sv
// Shift-register FIFO stage: serial storage chain, registered read port,
// occupancy flags and sticky overflow/underflow reporting.
module sr_fifo_ctrl
    import sr_fifo_pkg::*;
#(
    parameter  int depth = 8,
    parameter  int bits  = 1,
    localparam int PCW   = pcw(depth)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [bits-1:0] D_push,
    input  logic            pop,
    input  logic            clr_err,
    output logic [bits-1:0] D_pop,
    output logic            pop_valid,
    output logic [PCW-1:0]  pc,
    output logic            full,
    output logic            empty,
    output logic            almost_full,
    output logic            overflow,
    output logic            underflow
);

    localparam int IDXW = $clog2(depth);

    logic [bits-1:0] r_mem [depth];
    logic [bits-1:0] r_d_pop;
    logic            r_pop_valid;
    logic            r_overflow;
    logic            r_underflow;

    logic [PCW-1:0]  w_pc;
    logic            w_full;
    logic            w_empty;
    logic            w_almost_full;
    logic            w_push_ok;
    logic            w_pop_ok;
    logic            w_ovf_evt;
    logic            w_unf_evt;
    logic [IDXW-1:0] w_rd_idx;

    // A pop frees a slot in the same edge, so a full FIFO still takes a push.
    assign w_push_ok = push & (~w_full | pop);
    assign w_pop_ok  = pop & ~w_empty;
    assign w_ovf_evt = push & w_full & ~pop;
    assign w_unf_evt = pop & w_empty;

    assign w_rd_idx  = w_empty ? '0 : IDXW'(w_pc - PCW'(1));

    sr_occ_cnt #(
        .DEPTH (depth),
        .PCW   (PCW)
    ) u_occ (
        .i_clk         (clk),
        .i_rst_n       (reset),
        .i_push_ok     (w_push_ok),
        .i_pop_ok      (w_pop_ok),
        .o_pc          (w_pc),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_almost_full (w_almost_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++)
                r_mem[i] <= '0;
        end else if (w_push_ok) begin
            r_mem[0] <= D_push;
            for (int i = 1; i < depth; i++)
                r_mem[i] <= r_mem[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d_pop     <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= w_pop_ok;
            if (w_pop_ok)
                r_d_pop <= r_mem[w_rd_idx];
        end
    end

    // New error events take priority over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt)
                r_overflow <= 1'b1;
            else if (clr_err)
                r_overflow <= 1'b0;
            if (w_unf_evt)
                r_underflow <= 1'b1;
            else if (clr_err)
                r_underflow <= 1'b0;
        end
    end

    assign D_pop       = r_d_pop;
    assign pop_valid   = r_pop_valid;
    assign pc          = w_pc;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = w_almost_full;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_sr_fifo_ctrl.sv
// Self-checking bench for sr_fifo_ctrl against a queue-based FIFO model.
module tb_sr_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int BITS  = 1;
    localparam int PCW   = $clog2(DEPTH + 1);
    localparam int VW    = PCW + BITS + 6;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            push = 1'b0;
    logic [BITS-1:0] D_push = '0;
    logic            pop = 1'b0;
    logic            clr_err = 1'b0;
    logic [BITS-1:0] D_pop;
    logic            pop_valid;
    logic [PCW-1:0]  pc;
    logic            full;
    logic            empty;
    logic            almost_full;
    logic            overflow;
    logic            underflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [BITS-1:0] q[$];
    logic [BITS-1:0] m_dpop = '0;
    logic            m_pv = 1'b0;
    logic            m_ovf = 1'b0;
    logic            m_unf = 1'b0;

    logic [VW-1:0]   w_got;

    always #5 clk = ~clk;

    sr_fifo_ctrl #(
        .depth (DEPTH),
        .bits  (BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .D_push      (D_push),
        .pop         (pop),
        .clr_err     (clr_err),
        .D_pop       (D_pop),
        .pop_valid   (pop_valid),
        .pc          (pc),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    assign w_got = {pc, full, empty, almost_full, pop_valid, D_pop, overflow, underflow};

    function automatic logic [VW-1:0] exp_vec();
        int n;
        n = q.size();
        return {PCW'(n), (n == DEPTH), (n == 0), (n >= DEPTH - 1),
                m_pv, m_dpop, m_ovf, m_unf};
    endfunction

    task automatic model_reset();
        q.delete();
        m_dpop = '0;
        m_pv   = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Drive one cycle of requests and advance the model at the edge.
    task automatic cycle(input logic p, input logic [BITS-1:0] d,
                         input logic pp, input logic c);
        bit can_push;
        bit can_pop;
        @(negedge clk);
        push = p; D_push = d; pop = pp; clr_err = c;
        @(posedge clk);
        can_pop  = pp && (q.size() > 0);
        can_push = p && ((q.size() < DEPTH) || pp);
        m_pv = can_pop;
        if (can_pop)
            m_dpop = q.pop_front();
        if (can_push)
            q.push_back(d);
        if (p && !can_push)
            m_ovf = 1'b1;
        else if (c)
            m_ovf = 1'b0;
        if (pp && !can_pop)
            m_unf = 1'b1;
        else if (c)
            m_unf = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (w_got !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset: got %h exp %h", w_got, exp_vec());
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_fill_drain();
        logic [BITS-1:0] pat [8];
        pat = '{1, 0, 1, 1, 0, 0, 1, 0};
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, pat[i], 1'b0, 1'b0);
            n_cmp++;
            if (w_got !== exp_vec()) begin
                n_bad++;
                $display("FAIL fill[%0d]: got %h exp %h", i, w_got, exp_vec());
            end
            n_cmp++;
            if (pc !== PCW'(i + 1)) begin
                n_bad++;
                $display("FAIL fill_pc[%0d]: got %0d exp %0d", i, pc, i + 1);
            end
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            n_cmp++;
            if (w_got !== exp_vec()) begin
                n_bad++;
                $display("FAIL drain[%0d]: got %h exp %h", i, w_got, exp_vec());
            end
            n_cmp++;
            if (D_pop !== pat[i] || pop_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL drain_data[%0d]: got %h/%b exp %h/1",
                         i, D_pop, pop_valid, pat[i]);
            end
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (underflow !== 1'b1 || pop_valid !== 1'b0 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL underflow: got unf=%b pv=%b empty=%b exp 1/0/1",
                     underflow, pop_valid, empty);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (w_got !== exp_vec()) begin
            n_bad++;
            $display("FAIL unf_clear: got %h exp %h", w_got, exp_vec());
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, BITS'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (w_got !== exp_vec() || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow: got %h exp %h", w_got, exp_vec());
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (w_got !== exp_vec() || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: got %h exp %h", w_got, exp_vec());
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            n_cmp++;
            if (w_got !== exp_vec()) begin
                n_bad++;
                $display("FAIL ovf_drain[%0d]: got %h exp %h", i, w_got, exp_vec());
            end
        end
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (D_pop !== 1'b1 || pc !== PCW'(3) || w_got !== exp_vec()) begin
            n_bad++;
            $display("FAIL both_mid: got %h exp %h", w_got, exp_vec());
        end
        while (q.size() < DEPTH)
            cycle(1'b1, BITS'($urandom), 1'b0, 1'b0);
        cycle(1'b1, BITS'($urandom), 1'b1, 1'b0);
        n_cmp++;
        if (w_got !== exp_vec() || pc !== PCW'(DEPTH) || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL both_full: got %h exp %h", w_got, exp_vec());
        end
        while (q.size() > 0) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            n_cmp++;
            if (w_got !== exp_vec()) begin
                n_bad++;
                $display("FAIL both_drain: got %h exp %h", w_got, exp_vec());
            end
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (pc !== PCW'(1) || underflow !== 1'b1 || pop_valid !== 1'b0
            || w_got !== exp_vec()) begin
            n_bad++;
            $display("FAIL both_empty: got %h exp %h", w_got, exp_vec());
        end
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (w_got !== exp_vec()) begin
            n_bad++;
            $display("FAIL both_cleanup: got %h exp %h", w_got, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++)
            cycle(1'b1, BITS'($urandom), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (pc !== '0 || empty !== 1'b1 || D_pop !== '0 || w_got !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_async: got %h exp %h", w_got, exp_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (D_pop !== 1'b1 || pop_valid !== 1'b1 || w_got !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_resume: got %h exp %h", w_got, exp_vec());
        end
    endtask

    task automatic test_err_priority();
        cycle(1'b0, '0, 1'b1, 1'b1);
        n_cmp++;
        if (underflow !== 1'b1 || w_got !== exp_vec()) begin
            n_bad++;
            $display("FAIL err_prio: got unf=%b exp 1", underflow);
        end
        cycle(1'b0, '0, 1'b1, 1'b1);
        n_cmp++;
        if (underflow !== 1'b1) begin
            n_bad++;
            $display("FAIL err_prio_hold: got unf=%b exp 1", underflow);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (underflow !== 1'b0 || w_got !== exp_vec()) begin
            n_bad++;
            $display("FAIL err_clear: got unf=%b exp 0", underflow);
        end
    endtask

    task automatic test_random();
        logic p;
        logic pp;
        logic c;
        for (int k = 0; k < 400; k++) begin
            if (((k / 40) % 2) == 0) begin
                p  = ($urandom % 4) != 0;
                pp = ($urandom % 4) == 0;
            end else begin
                p  = ($urandom % 4) == 0;
                pp = ($urandom % 4) != 0;
            end
            c = ($urandom % 16) == 0;
            cycle(p, BITS'($urandom), pp, c);
            n_cmp++;
            if (w_got !== exp_vec()) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h exp %h", k, w_got, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        test_err_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
